// File: rtl/id_ex_hazard_responder_if.sv
// Stall/flush handshake and ID/EX register bundle between the hazard detector, ID stage and EX stage.
// STALL_PERF_CNT_EN adds the perf counter signals.
interface id_ex_hazard_responder_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic            stall_ip;
    logic            flush_ip;
    logic            ID_valid_ip;
    logic [6:0]      ID_instr_opcode_ip;
    logic [4:0]      ID_reg_dest_ip;
    logic [4:0]      ID_src1_addr_ip;
    logic [4:0]      ID_src2_addr_ip;
    logic            ID_write_reg_en_ip;
    logic [PC_W-1:0] ID_pc_ip;

    logic            pc_hold_op;
    logic            IF_ID_hold_op;
    logic            IF_ID_flush_op;
    logic            EX_valid_op;
    logic [6:0]      EX_instr_opcode_op;
    logic [4:0]      EX_reg_dest_op;
    logic [4:0]      EX_src1_addr_op;
    logic [4:0]      EX_src2_addr_op;
    logic            EX_write_reg_en_op;
    logic [PC_W-1:0] EX_pc_op;
    logic [1:0]      state_op;
    logic            stall_timeout_op;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_op;
    logic [CNT_W-1:0] flush_cycles_op;
    logic [CNT_W-1:0] bubbles_op;
`endif

    modport master (
        output stall_ip, flush_ip, ID_valid_ip, ID_instr_opcode_ip, ID_reg_dest_ip,
               ID_src1_addr_ip, ID_src2_addr_ip, ID_write_reg_en_ip, ID_pc_ip,
        input  pc_hold_op, IF_ID_hold_op, IF_ID_flush_op, EX_valid_op, EX_instr_opcode_op,
               EX_reg_dest_op, EX_src1_addr_op, EX_src2_addr_op, EX_write_reg_en_op,
               EX_pc_op, state_op, stall_timeout_op
`ifdef STALL_PERF_CNT_EN
        , stall_cycles_op, flush_cycles_op, bubbles_op
`endif
    );

    modport slave (
        input  stall_ip, flush_ip, ID_valid_ip, ID_instr_opcode_ip, ID_reg_dest_ip,
               ID_src1_addr_ip, ID_src2_addr_ip, ID_write_reg_en_ip, ID_pc_ip,
        output pc_hold_op, IF_ID_hold_op, IF_ID_flush_op, EX_valid_op, EX_instr_opcode_op,
               EX_reg_dest_op, EX_src1_addr_op, EX_src2_addr_op, EX_write_reg_en_op,
               EX_pc_op, state_op, stall_timeout_op
`ifdef STALL_PERF_CNT_EN
        , stall_cycles_op, flush_cycles_op, bubbles_op
`endif
    );
endinterface

// File: rtl/id_ex_hazard_responder.sv
// ID/EX pipeline register with stall/flush response FSM and consecutive-stall watchdog.
// Optional STALL_PERF_CNT_EN adds stall/flush/bubble performance counters.
module id_ex_hazard_responder #(
    parameter int PC_W             = 32,
    parameter int MAX_STALL_CYCLES = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    id_ex_hazard_responder_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    typedef struct packed {
        logic            valid;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            we;
        logic [PC_W-1:0] pc;
    } ex_t;

    localparam int   SC_W   = 8;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL_CYCLES);
    localparam ex_t  BUBBLE = '{valid: 1'b0, opcode: 7'h13, rd: 5'd0, rs1: 5'd0,
                                rs2: 5'd0, we: 1'b0, pc: '0};

    state_t          state_q, state_d;
    logic [SC_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    ex_t             ex_q, ex_d;
    logic            bubble_sel;
    logic            hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            ex_q      <= BUBBLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            ex_q      <= ex_d;
        end
    end

    always_comb begin
        state_d = RUN;
        cnt_d   = '0;
        case (state_q)
            RUN: begin
                if (bus.flush_ip) state_d = FLUSH;
                else if (bus.stall_ip) begin
                    state_d = STALL;
                    cnt_d   = SC_W'(1);
                end
            end
            STALL: begin
                if (bus.flush_ip) state_d = FLUSH;
                else if (bus.stall_ip) begin
                    state_d = STALL;
                    cnt_d   = (cnt_q >= SC_MAX) ? SC_MAX : cnt_q + SC_W'(1);
                end
            end
            FLUSH:   if (bus.flush_ip) state_d = FLUSH;
            default: state_d = RUN;
        endcase
        timeout_d = timeout_q | (cnt_d == SC_MAX);
    end

    // Only RUN/STALL with neither flush nor stall may capture; FLUSH-state ID is wrong-path.
    always_comb begin
        hold       = bus.stall_ip && !bus.flush_ip && (state_q != FLUSH) && !reset;
        bubble_sel = 1'b1;
        if ((state_q == RUN || state_q == STALL) && !bus.flush_ip && !bus.stall_ip)
            bubble_sel = !bus.ID_valid_ip;
        ex_d = bubble_sel ? BUBBLE :
               '{valid: 1'b1, opcode: bus.ID_instr_opcode_ip, rd: bus.ID_reg_dest_ip,
                 rs1: bus.ID_src1_addr_ip, rs2: bus.ID_src2_addr_ip,
                 we: bus.ID_write_reg_en_ip, pc: bus.ID_pc_ip};
    end

    assign bus.pc_hold_op         = hold;
    assign bus.IF_ID_hold_op      = hold;
    assign bus.IF_ID_flush_op     = bus.flush_ip && !reset;
    assign bus.EX_valid_op        = ex_q.valid;
    assign bus.EX_instr_opcode_op = ex_q.opcode;
    assign bus.EX_reg_dest_op     = ex_q.rd;
    assign bus.EX_src1_addr_op    = ex_q.rs1;
    assign bus.EX_src2_addr_op    = ex_q.rs2;
    assign bus.EX_write_reg_en_op = ex_q.we;
    assign bus.EX_pc_op           = ex_q.pc;
    assign bus.state_op           = state_q;
    assign bus.stall_timeout_op   = timeout_q;

`ifdef STALL_PERF_CNT_EN
    localparam int CW = $bits(bus.stall_cycles_op);
    logic [CW-1:0] stall_cyc_q, flush_cyc_q, bubbles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cyc_q <= '0;
            flush_cyc_q <= '0;
            bubbles_q   <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_q + CW'(state_d == STALL);
            flush_cyc_q <= flush_cyc_q + CW'(bus.flush_ip);
            bubbles_q   <= bubbles_q + CW'(bubble_sel);
        end
    end

    assign bus.stall_cycles_op = stall_cyc_q;
    assign bus.flush_cycles_op = flush_cyc_q;
    assign bus.bubbles_op      = bubbles_q;
`endif
endmodule

// File: tb/tb_id_ex_hazard_responder.sv
module tb_id_ex_hazard_responder;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  id_ex_hazard_responder_if #(.PC_W(32)) bus ();

  id_ex_hazard_responder #(.PC_W(32), .MAX_STALL_CYCLES(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [31:0] pc);
    bus.ID_valid_ip        = v;
    bus.ID_instr_opcode_ip = 7'h33;
    bus.ID_reg_dest_ip     = rd;
    bus.ID_src1_addr_ip    = 5'd1;
    bus.ID_src2_addr_ip    = 5'd2;
    bus.ID_write_reg_en_ip = 1'b1;
    bus.ID_pc_ip           = pc;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"},  bus.EX_valid_op, 1'b0);
    chk({tag, ".opcode"}, bus.EX_instr_opcode_op, 7'h13);
    chk({tag, ".rd"},     bus.EX_reg_dest_op, 5'd0);
    chk({tag, ".we"},     bus.EX_write_reg_en_op, 1'b0);
    chk({tag, ".pc"},     bus.EX_pc_op, 32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.stall_ip = 1'b1;
    bus.flush_ip = 1'b1;
    set_id(1'b1, 5'd5, 32'h40);
    #1;
    chk("rst.pc_hold",    bus.pc_hold_op, 1'b0);
    chk("rst.ifid_hold",  bus.IF_ID_hold_op, 1'b0);
    chk("rst.ifid_flush", bus.IF_ID_flush_op, 1'b0);
    repeat (3) step();
    chk_bubble("rst");
    chk("rst.state",   bus.state_op, 2'b00);
    chk("rst.timeout", bus.stall_timeout_op, 1'b0);

    reset = 1'b0; bus.stall_ip = 1'b0; bus.flush_ip = 1'b0;
    #1;
    chk("cap.hold", bus.pc_hold_op, 1'b0);
    step();
    chk("cap.valid",  bus.EX_valid_op, 1'b1);
    chk("cap.rd",     bus.EX_reg_dest_op, 5'd5);
    chk("cap.opcode", bus.EX_instr_opcode_op, 7'h33);
    chk("cap.rs1",    bus.EX_src1_addr_op, 5'd1);
    chk("cap.pc",     bus.EX_pc_op, 32'h40);
    chk("cap.state",  bus.state_op, 2'b00);

    set_id(1'b1, 5'd6, 32'h44);
    bus.stall_ip = 1'b1;
    #1;
    chk("lu.pc_hold",   bus.pc_hold_op, 1'b1);
    chk("lu.ifid_hold", bus.IF_ID_hold_op, 1'b1);
    step();
    chk_bubble("lu.e1");
    chk("lu.e1.state", bus.state_op, 2'b01);
    bus.stall_ip = 1'b0;
    #1;
    chk("lu.release_hold", bus.pc_hold_op, 1'b0);
    step();
    chk("lu.e2.pc",    bus.EX_pc_op, 32'h44);
    chk("lu.e2.valid", bus.EX_valid_op, 1'b1);
    chk("lu.e2.state", bus.state_op, 2'b00);
    set_id(1'b0, 5'd7, 32'h48);
    step();
    chk_bubble("invalid_id");

    set_id(1'b1, 5'd8, 32'h50);
    bus.stall_ip = 1'b1; bus.flush_ip = 1'b1;
    #1;
    chk("sf.hold",  bus.pc_hold_op, 1'b0);
    chk("sf.flush", bus.IF_ID_flush_op, 1'b1);
    step();
    chk_bubble("sf.e1");
    chk("sf.e1.state", bus.state_op, 2'b10);
    bus.flush_ip = 1'b0;
    #1;
    chk("fl.hold",  bus.IF_ID_hold_op, 1'b0);
    chk("fl.flush", bus.IF_ID_flush_op, 1'b0);
    step();
    chk_bubble("fl.e2");
    chk("fl.e2.state", bus.state_op, 2'b00);

    chk("wd.hold", bus.pc_hold_op, 1'b1);
    repeat (6) step();
    chk("wd.e6.timeout", bus.stall_timeout_op, 1'b0);
    chk("wd.e6.state",   bus.state_op, 2'b01);
    step();
    chk("wd.e7.timeout", bus.stall_timeout_op, 1'b1);
    repeat (2) step();
    chk("wd.e9.timeout", bus.stall_timeout_op, 1'b1);
    chk_bubble("wd.e9");
    bus.stall_ip = 1'b0;
    step();
    chk("wd.rel.pc",      bus.EX_pc_op, 32'h50);
    chk("wd.rel.state",   bus.state_op, 2'b00);
    chk("wd.rel.timeout", bus.stall_timeout_op, 1'b1);

    bus.stall_ip = 1'b1;
    repeat (2) step();
    chk("sfl.state_stall", bus.state_op, 2'b01);
    bus.flush_ip = 1'b1;
    step();
    chk("sfl.state_flush", bus.state_op, 2'b10);
    bus.stall_ip = 1'b0;
    step();
    chk("sfl.state_flush2", bus.state_op, 2'b10);
    chk_bubble("sfl.flush2");
    bus.flush_ip = 1'b0;
    step();
    chk("sfl.state_run", bus.state_op, 2'b00);
    chk_bubble("sfl.run");

    reset = 1'b1;
    step();
    chk("rst2.timeout", bus.stall_timeout_op, 1'b0);
    chk("rst2.state",   bus.state_op, 2'b00);

`ifdef STALL_PERF_CNT_EN
    reset = 1'b0;
    set_id(1'b1, 5'd6, 32'h44);
    bus.stall_ip = 1'b1;
    step();
    bus.stall_ip = 1'b0;
    step();
    bus.flush_ip = 1'b1;
    step();
    bus.flush_ip = 1'b0;
    step();
    chk("perf.stall",   bus.stall_cycles_op, 32'd1);
    chk("perf.flush",   bus.flush_cycles_op, 32'd1);
    chk("perf.bubbles", bus.bubbles_op, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_responder.md
Name: id_ex_hazard_responder

Overview:
Consumer end of the stall/flush protocol for the 5-stage RISCV core. It owns the ID/EX pipeline register. It answers the hazard detector's stall request by holding PC and IF/ID and injecting a bubble into EX. It answers an EX-resolved branch flush by clearing IF/ID and squashing the ID instruction. A consecutive-stall watchdog flags a hung hazard condition.

Parameters:
PC_W, 32, width of program counter fields
MAX_STALL_CYCLES, 7, consecutive stall cycles that trip the watchdog (1..255)
CNT_W, 32, width of performance counters (only with STALL_PERF_CNT_EN)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous active-high reset
stall_ip  input  1  stall request from hazard detector (combinational, same cycle)
flush_ip  input  1  branch/jump taken in EX; squash IF and ID
ID_valid_ip  input  1  ID holds a real instruction
ID_instr_opcode_ip  input  7  opcode in ID
ID_reg_dest_ip  input  5  rd in ID
ID_src1_addr_ip  input  5  rs1 in ID
ID_src2_addr_ip  input  5  rs2 in ID
ID_write_reg_en_ip  input  1  ID instruction writes rd
ID_pc_ip  input  PC_W  PC of ID instruction
pc_hold_op  output  1  freeze PC register
IF_ID_hold_op  output  1  freeze IF/ID register
IF_ID_flush_op  output  1  clear IF/ID to invalid next edge
EX_valid_op  output  1  registered valid
EX_instr_opcode_op  output  7  registered opcode
EX_reg_dest_op  output  5  registered rd
EX_src1_addr_op  output  5  registered rs1
EX_src2_addr_op  output  5  registered rs2
EX_write_reg_en_op  output  1  registered write enable
EX_pc_op  output  PC_W  registered PC
state_op  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH
stall_timeout_op  output  1  sticky watchdog flag

Behaviour:
- Bubble encoding: valid=0, opcode=7'h13 (OPIMM), rd=0, rs1=0, rs2=0, write_reg_en=0, pc=0. A bubble never creates a hazard downstream.
- Reset: on any edge with reset=1, the state goes to RUN, all EX_* outputs take the bubble value, the stall counter clears, and stall_timeout_op clears. Reset overrides every other input, including mid-stall and mid-flush.
- Hold/flush outputs are combinational:
  - pc_hold_op = IF_ID_hold_op = stall_ip && !flush_ip && state!=FLUSH && !reset.
  - IF_ID_flush_op = flush_ip && !reset.
- Priority: reset > flush_ip > stall_ip (when stall is honoured) > normal capture.
- RUN:
  - flush_ip=1: EX gets a bubble; go to FLUSH.
  - Else stall_ip=1: EX gets a bubble; stall counter=1; go to STALL.
  - Else EX captures the ID fields. If ID_valid_ip=0, EX gets a bubble instead.
- STALL:
  - flush_ip=1: bubble; counter clears; go to FLUSH.
  - stall_ip=1: bubble; counter increments, saturating at MAX_STALL_CYCLES; stay.
  - stall_ip=0: capture ID as in RUN; counter clears; go to RUN. The held instruction issues exactly once.
- FLUSH (one cycle; ID contents are wrong-path):
  - stall_ip is ignored; holds stay 0.
  - EX gets a bubble regardless of ID_valid_ip.
  - flush_ip=1 again: stay FLUSH. Otherwise go to RUN.
- Latency: the ID->EX capture is 1 cycle. A load-use stall costs exactly 1 bubble per stall_ip cycle.
- Watchdog: stall_timeout_op sets on the edge at which the counter reaches MAX_STALL_CYCLES. It stays high until reset and does not alter pipeline behaviour.
- State encoding 11 is unreachable; if entered, the next edge goes to RUN with a bubble.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined: adds outputs stall_cycles_op [CNT_W] (counts edges taken in STALL or entering it via stall_ip), flush_cycles_op [CNT_W] (counts edges where flush_ip=1), and bubbles_op [CNT_W] (counts edges that load a bubble into EX, reset excluded). All three clear on reset and wrap modulo 2^CNT_W.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles with stall_ip=1, flush_ip=1 -> holds 0, flush 0 during reset, EX = bubble (opcode 7'h13, valid 0), state_op=00, stall_timeout_op=0.
2. ID valid ADD rd=5 pc=0x40, no stall -> next edge EX_valid=1, EX_reg_dest=5, EX_pc=0x40, state 00.
3. Load-use: stall_ip=1 for one cycle with ID ADD pc=0x44:
   - During that cycle: pc_hold_op=IF_ID_hold_op=1.
   - Edge 1: EX = bubble, state 01.
   - Edge 2 (stall_ip=0): EX_pc=0x44 once, state 00.
4. stall_ip=1 and flush_ip=1 together in RUN -> holds 0, IF_ID_flush_op=1, EX bubble, state 10. Next cycle with stall_ip=1: holds stay 0, EX bubble, then state 00.
5. stall_ip=1 for 9 cycles with MAX_STALL_CYCLES=7 -> stall_timeout_op rises after the 7th stall edge and stays 1 after stall drops, until reset.
6. With STALL_PERF_CNT_EN: scenario 3 followed by one flush -> stall_cycles_op=1, flush_cycles_op=1, bubbles_op=3 (one stall bubble, plus flush and FLUSH-state bubbles).
